// File: rtl/hc595_scan_display.sv
// Multiplexed LED scanner driving a 74HC595-style chain.
// Each slot shifts {3'b111, sel, seg} MSB first, latches it, then dwells.
// Brightness below maximum adds a blank word and an OFF dwell to the slot.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | one bit period after reset, then slot 0
// SHIFT_ON  | 16 bit periods shifting the data word
// LATCH_ON  | one bit period with rck high
// DWELL_ON  | (b+1)*DWELL_UNIT bit periods showing the digit
// SHIFT_OFF | 16 bit periods shifting the blank word
// LATCH_OFF | one bit period with rck high
// DWELL_OFF | (BMAX-b)*DWELL_UNIT bit periods blanked
module hc595_scan_display #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCK_DIV     = 4,
  parameter int DWELL_UNIT  = 64,
  parameter int BRIGHT_BITS = 4,
  parameter int MODE        = 0,
  parameter int SEG_INVERT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DIGITS*8-1:0]  led_in,
  input  logic                     frame_load,
  output logic                     frame_ack,
  input  logic [NUM_DIGITS-1:0]    digit_en,
  input  logic [BRIGHT_BITS-1:0]   bright,
  output logic                     ser,
  output logic                     sck,
  output logic                     rck,
  output logic [4:0]               cur_digit
);

  localparam int DIV_W   = $clog2(SCK_DIV);
  localparam int BMAX    = (1 << BRIGHT_BITS) - 1;
  localparam int CNT_MAX = (BMAX + 1) * DWELL_UNIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 16);

  localparam logic [DIV_W-1:0]       DIV_LAST   = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]       DIV_HALF   = DIV_W'(SCK_DIV / 2);
  localparam logic [CNT_W-1:0]       SHIFT_LAST = CNT_W'(15);
  localparam logic [4:0]             LAST_DIGIT = 5'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_BITS-1:0] B_FULL     = BRIGHT_BITS'(BMAX);
  localparam logic [7:0]             SEG_XOR    = (SEG_INVERT != 0) ? 8'hFF : 8'h00;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_ON  = 3'd1;
  localparam logic [2:0] S_LATCH_ON  = 3'd2;
  localparam logic [2:0] S_DWELL_ON  = 3'd3;
  localparam logic [2:0] S_SHIFT_OFF = 3'd4;
  localparam logic [2:0] S_LATCH_OFF = 3'd5;
  localparam logic [2:0] S_DWELL_OFF = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        bits_q, bits_d;
  logic [4:0]              cur_digit_q, cur_digit_d;
  logic [BRIGHT_BITS-1:0]  b_q, b_d;
  logic [15:0]             word_q, word_d;
  logic [NUM_DIGITS*8-1:0] active_q, active_d, pending_q, pending_d;
  logic                    pend_q, pend_d, ack_q, ack_d;
  logic                    ser_q, ser_d, sck_q, sck_d, rck_q, rck_d;

  logic                    bit_end, slot_start, commit;
  logic [4:0]              dig_next, byte_idx;
  logic [7:0]              seg_sel;
  logic                    en_sel;
  logic [15:0]             data_word, blank_word;
  logic [CNT_W-1:0]        on_len, off_len;

  // Bit-period divider, next digit and slot-start / commit detection.
  always_comb begin
    bit_end = (div_q == DIV_LAST);
    div_d   = bit_end ? '0 : div_q + DIV_W'(1);
    if (state_q == S_IDLE || cur_digit_q == LAST_DIGIT) dig_next = '0;
    else dig_next = cur_digit_q + 5'd1;
    slot_start = 1'b0;
    if (bit_end) begin
      case (state_q)
        S_IDLE:      slot_start = 1'b1;
        S_DWELL_ON:  slot_start = (bits_q == '0) && (b_q == B_FULL);
        S_DWELL_OFF: slot_start = (bits_q == '0);
        default:     slot_start = 1'b0;
      endcase
    end
    commit = slot_start && (dig_next == '0) && (pend_q || frame_load);
  end

  // Double buffer: loads land in pending, commit copies to active at slot 0.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    if (commit) begin
      active_d = frame_load ? led_in : pending_q;
      pend_d   = 1'b0;
      ack_d    = 1'b1;
    end else if (frame_load) begin
      pending_d = led_in;
      pend_d    = 1'b1;
    end
  end

  // Word assembly; the data word reads the post-commit frame.
  always_comb begin
    byte_idx = (MODE == 0) ? LAST_DIGIT - dig_next : dig_next;
    seg_sel  = '0;
    en_sel   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (5'(i) == byte_idx) seg_sel = active_d[8*i +: 8];
      if (5'(i) == dig_next) en_sel = digit_en[i];
    end
    data_word  = {3'b111, dig_next, (en_sel ? seg_sel : 8'h00) ^ SEG_XOR};
    blank_word = {3'b111, cur_digit_q, SEG_XOR};
    on_len     = CNT_W'((int'(b_q) + 1) * DWELL_UNIT - 1);
    off_len    = CNT_W'((BMAX - int'(b_q)) * DWELL_UNIT - 1);
  end

  // Slot sequencer; bits_q counts remaining bit periods down to zero.
  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    cur_digit_d = cur_digit_q;
    b_d         = b_q;
    word_d      = word_q;
    if (slot_start) begin
      state_d     = S_SHIFT_ON;
      bits_d      = SHIFT_LAST;
      cur_digit_d = dig_next;
      b_d         = bright;
      word_d      = data_word;
    end else if (bit_end) begin
      case (state_q)
        S_SHIFT_ON, S_SHIFT_OFF: begin
          if (bits_q == '0) state_d = (state_q == S_SHIFT_ON) ? S_LATCH_ON : S_LATCH_OFF;
          else bits_d = bits_q - CNT_W'(1);
        end
        S_LATCH_ON: begin
          state_d = S_DWELL_ON;
          bits_d  = on_len;
        end
        S_DWELL_ON: begin
          if (bits_q == '0) begin
            state_d = S_SHIFT_OFF;
            bits_d  = SHIFT_LAST;
            word_d  = blank_word;
          end else begin
            bits_d = bits_q - CNT_W'(1);
          end
        end
        S_LATCH_OFF: begin
          state_d = S_DWELL_OFF;
          bits_d  = off_len;
        end
        S_DWELL_OFF: bits_d = bits_q - CNT_W'(1);
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Pin values; registered so ser/sck/rck move together one clk later.
  always_comb begin
    ser_d = 1'b0;
    sck_d = 1'b0;
    rck_d = (state_q == S_LATCH_ON) || (state_q == S_LATCH_OFF);
    if (state_q == S_SHIFT_ON || state_q == S_SHIFT_OFF) begin
      ser_d = word_q[bits_q[3:0]];
      sck_d = (div_q >= DIV_HALF);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bits_q      <= '0;
      cur_digit_q <= '0;
      b_q         <= '0;
      word_q      <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      ser_q       <= 1'b0;
      sck_q       <= 1'b0;
      rck_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      cur_digit_q <= cur_digit_d;
      b_q         <= b_d;
      word_q      <= word_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      ser_q       <= ser_d;
      sck_q       <= sck_d;
      rck_q       <= rck_d;
    end
  end

  assign ser       = ser_q;
  assign sck       = sck_q;
  assign rck       = rck_q;
  assign frame_ack = ack_q;
  assign cur_digit = cur_digit_q;

endmodule

// File: tb/tb_hc595_scan_display.sv
// Scoreboard bench for hc595_scan_display: stimulus pushes expected latched
// words (and rck spacing), monitors decode ser/sck/rck and pop on each rck.
module tb_hc595_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DU = 2;
  localparam int BB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_load = 1'b0;
  logic [31:0]   led_in = 32'h0;
  logic [ND-1:0] digit_en = 4'hF;
  logic [BB-1:0] bright = 2'd3;
  logic          frame_ack, ser, sck, rck;
  logic [4:0]    cur_digit;

  logic [31:0]   led_in2 = 32'h12345678;
  logic [ND-1:0] digit_en2 = 4'hF;
  logic [BB-1:0] bright2 = 2'd3;
  logic          frame_ack2, ser2, sck2, rck2;
  logic [4:0]    cur_digit2;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  typedef struct {
    logic [15:0] w;
    int          gap;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] exp2_q[$];

  logic [15:0] w_m0[4]  = '{16'hE012, 16'hE134, 16'hE256, 16'hE378};
  logic [15:0] w_m1[4]  = '{16'hE087, 16'hE1A9, 16'hE2CB, 16'hE3ED};
  logic [15:0] w_55[4]  = '{16'hE055, 16'hE155, 16'hE255, 16'hE355};
  logic [15:0] w_co[4]  = '{16'hE00F, 16'hE11E, 16'hE22D, 16'hE33C};

  always #5 clk = ~clk;

  hc595_scan_display #(
    .NUM_DIGITS(ND), .SCK_DIV(SD), .DWELL_UNIT(DU), .BRIGHT_BITS(BB),
    .MODE(0), .SEG_INVERT(0)
  ) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .frame_load(frame_load),
    .frame_ack(frame_ack), .digit_en(digit_en), .bright(bright),
    .ser(ser), .sck(sck), .rck(rck), .cur_digit(cur_digit)
  );

  hc595_scan_display #(
    .NUM_DIGITS(ND), .SCK_DIV(SD), .DWELL_UNIT(DU), .BRIGHT_BITS(BB),
    .MODE(1), .SEG_INVERT(1)
  ) dut2 (
    .clk(clk), .rst(rst), .led_in(led_in2), .frame_load(frame_load),
    .frame_ack(frame_ack2), .digit_en(digit_en2), .bright(bright2),
    .ser(ser2), .sck(sck2), .rck(rck2), .cur_digit(cur_digit2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] w, input int gap);
    exp_t e;
    e.w   = w;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("queue_drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_slot(input int d);
    logic [4:0] p;
    bit         hit = 1'b0;
    p = cur_digit;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(negedge clk);
      if (int'(cur_digit) == d && int'(p) != d) hit = 1'b1;
      p = cur_digit;
    end
    if (!hit) chk("wait_slot_timeout", 0, 1);
  endtask

  // Monitor for the MODE=0 instance: words, rck spacing, rck width, acks.
  logic [15:0] sh = 16'h0;
  logic        sck_p = 1'b0, rck_p = 1'b0;
  int          cyc = 0, last_rck = 0, rck_w = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sck && !sck_p) sh = {sh[14:0], ser};
      if (rck && !rck_p) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("word", int'(sh), int'(e.w));
          if (e.gap != 0) chk("rck_gap", cyc - last_rck, e.gap);
        end
        last_rck = cyc;
        rck_w    = 0;
      end
      if (rck) rck_w++;
      if (!rck && rck_p) chk("rck_width", rck_w, SD);
      if (frame_ack) ack_cnt++;
      sck_p = sck;
      rck_p = rck;
    end
  end

  // Monitor for the MODE=1 / inverted-segment instance.
  logic [15:0] sh2 = 16'h0;
  logic        sck2_p = 1'b0, rck2_p = 1'b0;
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (sck2 && !sck2_p) sh2 = {sh2[14:0], ser2};
      if (rck2 && !rck2_p && exp2_q.size() > 0) begin
        w = exp2_q.pop_front();
        chk("word_mode1_inv", int'(sh2), int'(w));
      end
      sck2_p = sck2;
      rck2_p = rck2;
    end
  end

  initial begin
    int a0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ser", int'(ser), 0);
    chk("rst_sck", int'(sck), 0);
    chk("rst_rck", int'(rck), 0);
    chk("rst_ack", int'(frame_ack), 0);
    chk("rst_cur_digit", int'(cur_digit), 0);

    // Scenario 1 (and 2 on the second instance): first frame at full brightness
    rst        = 1'b0;
    led_in     = 32'h12345678;
    frame_load = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++) begin
        push(w_m0[d], (r == 0 && d == 0) ? 0 : 100);
        exp2_q.push_back(w_m1[d]);
      end
    @(negedge clk);
    frame_load = 1'b0;
    wait_empty();
    chk("ack_first_frame", ack_cnt, 1);

    // Scenario 3: bright=1 interleaves blank words
    bright = 2'd1;
    wait_slot(0);
    for (int d = 0; d < 4; d++) begin
      push(w_m0[d], (d == 0) ? 0 : 84);
      push(16'(16'hE000 + d * 256), 84);
    end
    wait_empty();

    // Scenario 4: digit 2 disabled mid-slot 2
    bright = 2'd3;
    wait_slot(2);
    digit_en = 4'b1011;
    push(16'hE256, 0);
    push(16'hE378, 100);
    push(16'hE012, 100);
    push(16'hE134, 100);
    push(16'hE200, 100);
    push(16'hE378, 100);
    wait_empty();
    digit_en = 4'hF;

    // Scenario 5: two loads during slot 1, latest wins
    wait_slot(1);
    a0         = ack_cnt;
    led_in     = 32'hAAAAAAAA;
    frame_load = 1'b1;
    @(negedge clk);
    frame_load = 1'b0;
    repeat (5) @(negedge clk);
    led_in     = 32'h55555555;
    frame_load = 1'b1;
    @(negedge clk);
    frame_load = 1'b0;
    push(16'hE134, 0);
    push(16'hE256, 100);
    push(16'hE378, 100);
    for (int d = 0; d < 4; d++) push(w_55[d], 100);
    wait_slot(0);
    repeat (4) @(negedge clk);
    chk("ack_after_double_load", ack_cnt, a0 + 1);

    // Load coincident with the next slot-0 start: rck rise + 35 clk
    wait_slot(3);
    @(posedge rck);
    for (int d = 0; d < 4; d++) push(w_co[d], 100);
    repeat (34) @(posedge clk);
    #1;
    led_in     = 32'h0F1E2D3C;
    frame_load = 1'b1;
    @(posedge clk);
    #1;
    frame_load = 1'b0;
    wait_empty();
    chk("ack_coincident_load", ack_cnt, a0 + 2);

    // Scenario 6: reset during bit 7 of SHIFT_ON
    wait_slot(1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ser", int'(ser), 0);
    chk("midrst_sck", int'(sck), 0);
    chk("midrst_rck", int'(rck), 0);
    chk("midrst_cur_digit", int'(cur_digit), 0);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) push(16'(16'hE000 + d * 256), (d == 0) ? 0 : 100);
    wait_empty();
    chk("ack_after_reset", ack_cnt, a0 + 2);
    chk("mode1_queue_drained", exp2_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
